// File: rtl/matmul_tile_scheduler.sv
// Walks an n_tiles x k_tiles job over the systolic matrix_mult_wrapper:
// programs per-tile offsets, pulses start, waits for done, then advances k-major.
module matmul_tile_scheduler #(
  parameter int ROW     = 4,
  parameter int COL     = 4,
  parameter int W_SIZE  = 256,
  parameter int I_SIZE  = 256,
  parameter int O_SIZE  = 256,
  parameter int TIMEOUT = 20000,
  localparam int WA = $clog2(W_SIZE),
  localparam int IA = $clog2(I_SIZE),
  localparam int OA = $clog2(O_SIZE),
  localparam int TW = $clog2(TIMEOUT) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          job_valid_i,
  output logic          job_ready_o,
  input  logic [WA-1:0] w_base_i,
  input  logic [IA-1:0] i_base_i,
  input  logic [OA-1:0] o_base_i,
  input  logic [IA-1:0] i_rows_i,
  input  logic [IA-1:0] i_stride_i,
  input  logic [OA-1:0] o_stride_i,
  input  logic [3:0]    k_tiles_i,
  input  logic [3:0]    n_tiles_i,
  input  logic          abort_i,
  output logic          mm_start_o,
  input  logic          mm_done_i,
  output logic [WA-1:0] w_offset_o,
  output logic [IA-1:0] i_offset_o,
  output logic [OA-1:0] psum_offset_o,
  output logic [OA-1:0] o_offset_o,
  output logic [IA-1:0] i_rows_o,
  output logic          accum_en_o,
  output logic          busy_o,
  output logic          job_done_o,
  output logic          err_o,
  output logic [3:0]    tile_k_o,
  output logic [3:0]    tile_n_o
);

  if (ROW < 1 || COL < 1) begin : g_bad_geometry
    $error("matmul_tile_scheduler: ROW and COL must be at least 1");
  end

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_ADVANCE, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [WA-1:0] w_base_q, w_base_d, w_off_q, w_off_d;
  logic [IA-1:0] i_base_q, i_base_d, i_stride_q, i_stride_d, i_off_q, i_off_d;
  logic [IA-1:0] i_rows_q, i_rows_d;
  logic [OA-1:0] o_base_q, o_base_d, o_stride_q, o_stride_d, o_off_q, o_off_d;
  logic [3:0]    k_tiles_q, k_tiles_d, n_tiles_q, n_tiles_d;
  logic [3:0]    k_q, k_d, n_q, n_d;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          start_q, start_d, done_q, done_d, err_q, err_d;
  logic          busy_q, busy_d, ready_q, ready_d, accum_q, accum_d;

  always_comb begin
    state_d    = state_q;
    w_base_d   = w_base_q;
    i_base_d   = i_base_q;
    o_base_d   = o_base_q;
    i_stride_d = i_stride_q;
    o_stride_d = o_stride_q;
    i_rows_d   = i_rows_q;
    k_tiles_d  = k_tiles_q;
    n_tiles_d  = n_tiles_q;
    k_d        = k_q;
    n_d        = n_q;
    cnt_d      = cnt_q;
    err_d      = err_q;
    w_off_d    = w_off_q;
    i_off_d    = i_off_q;
    o_off_d    = o_off_q;
    accum_d    = accum_q;
    start_d    = 1'b0;
    done_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (job_valid_i && ready_q) begin
          w_base_d   = w_base_i;
          i_base_d   = i_base_i;
          o_base_d   = o_base_i;
          i_stride_d = i_stride_i;
          o_stride_d = o_stride_i;
          i_rows_d   = i_rows_i;
          k_tiles_d  = k_tiles_i;
          n_tiles_d  = n_tiles_i;
          k_d        = 4'd0;
          n_d        = 4'd0;
          state_d    = (k_tiles_i == 4'd0 || n_tiles_i == 4'd0) ? S_DONE : S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (mm_done_i) begin
          state_d = S_ADVANCE;
        end else if (cnt_q == TW'(TIMEOUT - 1)) begin
          state_d = S_ERR;
        end
      end
      S_ADVANCE: begin
        if ({1'b0, k_q} + 5'd1 < {1'b0, k_tiles_q}) begin
          k_d     = k_q + 4'd1;
          state_d = S_ISSUE;
        end else if ({1'b0, n_q} + 5'd1 < {1'b0, n_tiles_q}) begin
          k_d     = 4'd0;
          n_d     = n_q + 4'd1;
          state_d = S_ISSUE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase

    // Abort overrides every transition above, including a pending ISSUE.
    if (abort_i && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      k_d     = 4'd0;
      n_d     = 4'd0;
      err_d   = 1'b0;
    end

    if (state_d == S_ISSUE) begin
      start_d = 1'b1;
      w_off_d = w_base_d + WA'((32'(n_d) * 32'(k_tiles_d) + 32'(k_d)) * 32'(ROW));
      i_off_d = i_base_d + IA'(32'(k_d) * 32'(i_stride_d));
      o_off_d = o_base_d + OA'(32'(n_d) * 32'(o_stride_d));
      accum_d = (k_d != 4'd0);
    end
    if (state_d == S_DONE) done_d = 1'b1;
    if (state_d == S_ERR)  err_d  = 1'b1;
    busy_d  = (state_d != S_IDLE);
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      w_base_q   <= '0;
      i_base_q   <= '0;
      o_base_q   <= '0;
      i_stride_q <= '0;
      o_stride_q <= '0;
      i_rows_q   <= '0;
      k_tiles_q  <= '0;
      n_tiles_q  <= '0;
      k_q        <= '0;
      n_q        <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      w_off_q    <= '0;
      i_off_q    <= '0;
      o_off_q    <= '0;
      accum_q    <= 1'b0;
      start_q    <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      w_base_q   <= w_base_d;
      i_base_q   <= i_base_d;
      o_base_q   <= o_base_d;
      i_stride_q <= i_stride_d;
      o_stride_q <= o_stride_d;
      i_rows_q   <= i_rows_d;
      k_tiles_q  <= k_tiles_d;
      n_tiles_q  <= n_tiles_d;
      k_q        <= k_d;
      n_q        <= n_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      w_off_q    <= w_off_d;
      i_off_q    <= i_off_d;
      o_off_q    <= o_off_d;
      accum_q    <= accum_d;
      start_q    <= start_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      ready_q    <= ready_d;
    end
  end

  assign job_ready_o   = ready_q;
  assign mm_start_o    = start_q;
  assign w_offset_o    = w_off_q;
  assign i_offset_o    = i_off_q;
  assign psum_offset_o = o_off_q;
  assign o_offset_o    = o_off_q;
  assign i_rows_o      = i_rows_q;
  assign accum_en_o    = accum_q;
  assign busy_o        = busy_q;
  assign job_done_o    = done_q;
  assign err_o         = err_q;
  assign tile_k_o      = k_q;
  assign tile_n_o      = n_q;

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// Directed + randomized bench for matmul_tile_scheduler; the bench plays the
// wrapper and predicts every tile's offsets from the job descriptor.
module tb_matmul_tile_scheduler;
  localparam int TO = 40;

  logic       clk, rst;
  logic       job_valid, job_ready, abort, mm_start, mm_done;
  logic [7:0] w_base, i_base, o_base, i_rows, i_stride, o_stride;
  logic [3:0] k_tiles, n_tiles, tile_k, tile_n;
  logic [7:0] w_off, i_off, psum_off, o_off, i_rows_out;
  logic       accum_en, busy, job_done, err;

  int n_pass = 0;
  int n_checks = 0;

  matmul_tile_scheduler #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .job_valid_i(job_valid), .job_ready_o(job_ready),
    .w_base_i(w_base), .i_base_i(i_base), .o_base_i(o_base),
    .i_rows_i(i_rows), .i_stride_i(i_stride), .o_stride_i(o_stride),
    .k_tiles_i(k_tiles), .n_tiles_i(n_tiles), .abort_i(abort),
    .mm_start_o(mm_start), .mm_done_i(mm_done),
    .w_offset_o(w_off), .i_offset_o(i_off), .psum_offset_o(psum_off),
    .o_offset_o(o_off), .i_rows_o(i_rows_out), .accum_en_o(accum_en),
    .busy_o(busy), .job_done_o(job_done), .err_o(err),
    .tile_k_o(tile_k), .tile_n_o(tile_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Presents a descriptor for one cycle, then scrambles the inputs so only
  // the captured copy can explain later outputs.
  task automatic accept(input logic [7:0] wb, ib, ob, rows, is, os,
                        input logic [3:0] kt, nt);
    chk("ready_before_accept", job_ready, 1);
    w_base = wb; i_base = ib; o_base = ob; i_rows = rows;
    i_stride = is; o_stride = os; k_tiles = kt; n_tiles = nt;
    job_valid = 1'b1;
    step();
    job_valid = 1'b0;
    w_base = 8'($urandom); i_base = 8'($urandom); o_base = 8'($urandom);
    i_rows = 8'($urandom); i_stride = 8'($urandom); o_stride = 8'($urandom);
    k_tiles = 4'($urandom); n_tiles = 4'($urandom);
  endtask

  // Runs a whole job; tiles are visited n-outer, k-inner.
  task automatic run_job(input logic [7:0] wb, ib, ob, rows, is, os,
                         input logic [3:0] kt, nt, input int fixed_d);
    logic [7:0] ew, ei, eo;
    int d;
    $display("job: w=%02h i=%02h o=%02h is=%0d os=%0d k=%0d n=%0d", wb, ib, ob, is, os, kt, nt);
    accept(wb, ib, ob, rows, is, os, kt, nt);
    for (int n = 0; n < int'(nt); n++) begin
      for (int k = 0; k < int'(kt); k++) begin
        ew = wb + 8'((n * int'(kt) + k) * 4);
        ei = ib + 8'(k * int'(is));
        eo = ob + 8'(n * int'(os));
        chk("start_pulse", mm_start, 1);
        chk("tile_k", tile_k, 32'(k));
        chk("tile_n", tile_n, 32'(n));
        chk("w_offset", w_off, ew);
        chk("i_offset", i_off, ei);
        chk("o_offset", o_off, eo);
        chk("psum_offset", psum_off, eo);
        chk("accum_en", accum_en, (k != 0) ? 1 : 0);
        chk("i_rows_out", i_rows_out, rows);
        chk("busy_in_job", busy, 1);
        chk("ready_in_job", job_ready, 0);
        $display("tile n=%0d k=%0d w=%02h i=%02h o=%02h acc=%0d", n, k, w_off, i_off, o_off, accum_en);
        d = (fixed_d >= 0) ? fixed_d : int'($urandom_range(0, 5));
        mm_done = 1'($urandom_range(0, 1));
        step();
        mm_done = 1'b0;
        for (int j = 0; j < d; j++) begin
          chk("no_start_in_wait", mm_start, 0);
          step();
        end
        mm_done = 1'b1;
        step();
        mm_done = 1'b0;
        chk("no_start_in_advance", mm_start, 0);
        chk("no_done_in_advance", job_done, 0);
        step();
      end
    end
    chk("job_done_pulse", job_done, 1);
    chk("no_start_at_done", mm_start, 0);
    step();
    chk("job_done_one_cycle", job_done, 0);
    chk("ready_after_job", job_ready, 1);
    chk("idle_after_job", busy, 0);
  endtask

  task automatic zero_job(input logic [3:0] kt, nt);
    $display("job: zero tiles k=%0d n=%0d", kt, nt);
    accept(8'h11, 8'h22, 8'h33, 8'h04, 8'h01, 8'h01, kt, nt);
    chk("zero_done_pulse", job_done, 1);
    chk("zero_no_start", mm_start, 0);
    step();
    chk("zero_done_one_cycle", job_done, 0);
    chk("zero_ready_again", job_ready, 1);
    chk("zero_no_start_after", mm_start, 0);
  endtask

  initial begin
    rst = 1'b1; job_valid = 1'b0; abort = 1'b0; mm_done = 1'b0;
    w_base = '0; i_base = '0; o_base = '0; i_rows = '0; i_stride = '0; o_stride = '0;
    k_tiles = '0; n_tiles = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    chk("rst_ready", job_ready, 1);
    chk("rst_start", mm_start, 0);
    chk("rst_w_off", w_off, 0);
    chk("rst_i_off", i_off, 0);
    chk("rst_o_off", o_off, 0);
    chk("rst_psum_off", psum_off, 0);
    chk("rst_i_rows", i_rows_out, 0);
    chk("rst_accum", accum_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", job_done, 0);
    chk("rst_err", err, 0);
    chk("rst_tile_k", tile_k, 0);
    chk("rst_tile_n", tile_n, 0);
    step();

    // abort while idle must not disturb anything
    abort = 1'b1;
    step();
    abort = 1'b0;
    chk("idle_abort_ready", job_ready, 1);
    chk("idle_abort_busy", busy, 0);
    step();

    run_job(8'h10, 8'h20, 8'h40, 8'h08, 8'h00, 8'h00, 4'd1, 4'd1, 29);
    step();
    run_job(8'h00, 8'h00, 8'h00, 8'h10, 8'h08, 8'h04, 4'd2, 4'd2, 9);
    step();
    run_job(8'hFC, 8'h00, 8'h00, 8'h04, 8'h10, 8'h00, 4'd2, 4'd1, -1);
    step();
    zero_job(4'd0, 4'd3);
    step();
    zero_job(4'd2, 4'd0);
    step();

    for (int r = 0; r < 5; r++) begin
      run_job(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              8'($urandom), 8'($urandom),
              4'($urandom_range(1, 3)), 4'($urandom_range(1, 3)), -1);
      step();
    end

    // Timeout: start at S, TO cycles of WAIT, ERR visible at S+TO+1.
    $display("job: timeout, done never arrives");
    accept(8'h08, 8'h00, 8'h00, 8'h04, 8'h01, 8'h01, 4'd1, 4'd1);
    chk("to_start", mm_start, 1);
    for (int j = 0; j < TO; j++) step();
    chk("to_err_not_yet", err, 0);
    step();
    chk("to_err_set", err, 1);
    chk("to_busy", busy, 1);
    chk("to_not_ready", job_ready, 0);
    repeat (3) step();
    chk("to_err_sticky", err, 1);
    abort = 1'b1;
    mm_done = 1'b1;
    step();
    abort = 1'b0;
    mm_done = 1'b0;
    chk("abort_err_clear", err, 0);
    chk("abort_idle", busy, 0);
    chk("abort_ready", job_ready, 1);
    chk("abort_no_done", job_done, 0);
    chk("abort_tile_k", tile_k, 0);
    step();
    chk("abort_no_done_later", job_done, 0);
    chk("abort_no_start", mm_start, 0);

    // abort colliding with done mid-job: no advance, no start, no job_done
    $display("job: abort together with done while waiting");
    accept(8'h00, 8'h00, 8'h00, 8'h04, 8'h01, 8'h01, 4'd2, 4'd2);
    chk("mid_start", mm_start, 1);
    step();
    step();
    abort = 1'b1;
    mm_done = 1'b1;
    step();
    abort = 1'b0;
    mm_done = 1'b0;
    chk("mid_abort_idle", busy, 0);
    chk("mid_abort_no_done", job_done, 0);
    chk("mid_abort_no_start", mm_start, 0);
    step();
    chk("mid_abort_no_start_later", mm_start, 0);
    chk("mid_abort_no_done_later", job_done, 0);
    step();

    run_job(8'h30, 8'h05, 8'h70, 8'h02, 8'h03, 8'h09, 4'd3, 4'd2, -1);
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/matmul_tile_scheduler.md
Name: matmul_tile_scheduler

Overview:
Sequences multi-tile matrix multiplications on the systolic matrix_mult_wrapper. It accepts one job descriptor through a valid/ready handshake and walks an n_tiles x k_tiles loop. For each tile it programs the data_config fields (weight, input, psum and output offsets, plus accum_en), pulses start and waits for the wrapper's done. It sits between the host/config register file and matrix_mult_wrapper, and replaces bench-driven start_i sequencing.

Parameters:
ROW, 4, systolic array rows; weight tile height in weight-memory words
COL, 4, systolic array columns
W_SIZE, 256, weight memory depth; WA = $clog2(W_SIZE)
I_SIZE, 256, input memory depth; IA = $clog2(I_SIZE)
O_SIZE, 256, output memory depth; OA = $clog2(O_SIZE)
TIMEOUT, 20000, max cycles spent waiting for done per tile; TW = $clog2(TIMEOUT)+1

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
job_valid_i  in  1  job descriptor valid
job_ready_o  out  1  scheduler idle and able to accept a job
w_base_i  in  WA  weight base address
i_base_i  in  IA  input base address
o_base_i  in  OA  output base address
i_rows_i  in  IA  streaming rows per tile, passed through to the wrapper
i_stride_i  in  IA  input address step per k tile
o_stride_i  in  OA  output address step per n tile
k_tiles_i  in  4  reduction tiles per output block
n_tiles_i  in  4  output blocks
abort_i  in  1  cancel the current job
mm_start_o  out  1  one-cycle start pulse to the wrapper
mm_done_i  in  1  wrapper done
w_offset_o  out  WA  weight offset for the current tile
i_offset_o  out  IA  input offset for the current tile
psum_offset_o  out  OA  psum read offset for the current tile
o_offset_o  out  OA  output write offset for the current tile
i_rows_o  out  IA  registered copy of i_rows_i
accum_en_o  out  1  accumulate onto psum
busy_o  out  1  state is not IDLE
job_done_o  out  1  one-cycle pulse when the job completes
err_o  out  1  sticky timeout flag
tile_k_o  out  4  current k index
tile_n_o  out  4  current n index

Behaviour:
- Reset values: all outputs 0, with one exception: job_ready_o = 1. State resets to IDLE and all counters reset to 0.
- States: IDLE, ISSUE, WAIT, ADVANCE, DONE, ERR.
- IDLE:
  - job_ready_o = 1.
  - On job_valid_i & job_ready_o at cycle T, all descriptor fields are registered.
  - If k_tiles_i == 0 or n_tiles_i == 0, go to DONE: no start is issued, and job_done_o pulses at T+1.
  - Otherwise go to ISSUE with k = n = 0.
- ISSUE:
  - Lasts one cycle; mm_start_o = 1.
  - The offset outputs are already stable in this cycle and stay stable until ADVANCE.
  - Next state is WAIT. The first start therefore occurs at T+1.
- WAIT:
  - A timeout counter increments every cycle.
  - The first cycle with mm_done_i = 1 goes to ADVANCE. mm_done_i seen during ISSUE is ignored.
  - If the counter reaches TIMEOUT before done, go to ERR.
- ADVANCE:
  - Lasts one cycle.
  - If k + 1 < k_tiles: k++.
  - Else if n + 1 < n_tiles: k = 0, n++.
  - Else go to DONE.
  - When not going to DONE, go to ISSUE. Done at cycle D therefore gives the next start at D+2.
- DONE: job_done_o = 1 for one cycle, then IDLE.
- ERR: err_o = 1 and busy_o = 1. Stays in ERR until abort_i or reset.
- Address math (all sums truncate to the port width, i.e. wrap modulo the memory size):
  - w_offset_o = w_base + (n*k_tiles + k)*ROW
  - i_offset_o = i_base + k*i_stride
  - o_offset_o = psum_offset_o = o_base + n*o_stride
  - accum_en_o = (k != 0)
- Offsets are registered outputs, updated in the same cycle the state enters ISSUE.
- abort_i:
  - In any state other than IDLE, the next state is IDLE.
  - Clears err_o and the counters.
  - No job_done_o pulse. A start pulse is suppressed if abort_i is high in the cycle that would be ISSUE.
  - abort_i in IDLE has no effect.
- Simultaneous events:
  - abort_i wins over mm_done_i and over timeout.
  - rst_i wins over everything.
- Reset mid-job returns to IDLE with no done pulse.
- New jobs are not accepted while busy: job_ready_o = 0.

Test Plan:
- Reset: hold rst_i 2 cycles -> job_ready_o = 1, all other outputs 0, state IDLE.
- Single tile: w_base=0x10, i_base=0x20, o_base=0x40, k=1, n=1; mm_done_i at start+30 -> one start, w_off=0x10, i_off=0x20, o_off=0x40, accum_en=0; job_done_o at done+2.
- 2x2 job: w_base=0, i_base=0, i_stride=8, o_stride=4, k=2, n=2; done 10 cycles after each start:
  - 4 starts with (k,n) = (0,0),(1,0),(0,1),(1,1).
  - w_off = 0,4,8,12; i_off = 0,8,0,8; o_off = 0,0,4,4; accum_en = 0,1,0,1.
  - Gap from each done to the next start is exactly 2 cycles.
- Wrap: w_base=0xFC, k=2, n=1 -> w_off = 0xFC then 0x00; no X.
- Zero tiles: k_tiles=0 -> no mm_start_o pulse, job_done_o 1 cycle after accept, job_ready_o high again next cycle.
- Timeout/abort: never assert done -> err_o = 1 after TIMEOUT cycles in WAIT, busy_o = 1. Then assert abort_i together with mm_done_i -> IDLE, err_o = 0, no job_done_o.
